// File: rtl/tl_ul_pkg.sv
// Shared TL-UL opcodes, RISC-V load/store opcodes and channel field offsets
// for the multi-outstanding load/store master.
package tl_ul_pkg;
  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  // A channel: {opcode, param, size, source, address, data}
  function automatic int a_src_lsb(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int a_op_lsb(input int addr_w, input int data_w, input int src_w);
    return src_w + addr_w + data_w + 6;
  endfunction

  // D channel: {opcode, param, size, source, error, data}
  function automatic int d_err_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int d_src_lsb(input int data_w);
    return data_w + 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with valid/ready on both sides and a
// combinational read port (head visible while out_valid).
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         push, pop;

  // Extra pointer bit distinguishes full from empty.
  assign in_ready  = (wptr ^ rptr) != {1'b1, {AW{1'b0}}};
  assign out_valid = wptr != rptr;
  assign out_data  = mem[rptr[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= in_data;
  end
endmodule

// File: rtl/tl_ul_master_mo.sv
// TL-UL load/store master: buffers pipeline requests, keeps one transaction
// in flight per source ID, re-issues errored beats and returns tagged responses.
module tl_ul_master_mo
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int SRC_W      = 2,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 2,
  parameter int SIZE_LOG2  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [6:0]                      req_opcode,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [DATA_W-1:0]               req_wdata,
  input  logic [TAG_W-1:0]                req_tag,
  output logic [9+SRC_W+ADDR_W+DATA_W-1:0] a_channel,
  output logic                            a_valid,
  input  logic                            a_ready,
  input  logic [10+SRC_W+DATA_W-1:0]      d_channel,
  input  logic                            d_valid,
  output logic                            d_ready,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_W-1:0]               rsp_data,
  output logic [TAG_W-1:0]                rsp_tag,
  output logic                            rsp_err,
  output logic                            proto_err
);
  localparam int NSRC   = 1 << SRC_W;
  localparam int A_W    = 9 + SRC_W + ADDR_W + DATA_W;
  localparam int D_W    = 10 + SRC_W + DATA_W;
  localparam int FW     = 2 + ADDR_W + DATA_W + TAG_W;
  localparam int RCNT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // Request FIFO: entries carry {bad_op, is_load, addr, wdata, tag}.
  logic              h_valid, h_bad, h_load, fifo_pop;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [TAG_W-1:0]  h_tag;
  logic              in_bad;

  assign in_bad = !(req_opcode == OP_LW || req_opcode == OP_SW);

  sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (req_valid),
    .in_ready  (req_ready),
    .in_data   ({in_bad, req_opcode == OP_LW, req_addr, req_wdata, req_tag}),
    .out_valid (h_valid),
    .out_ready (fifo_pop),
    .out_data  ({h_bad, h_load, h_addr, h_wdata, h_tag})
  );

  // Source table
  logic [NSRC-1:0]   busy, rpend, is_load;
  logic [RCNT_W-1:0] rcnt    [NSRC];
  logic [ADDR_W-1:0] e_addr  [NSRC];
  logic [DATA_W-1:0] e_wdata [NSRC];
  logic [TAG_W-1:0]  e_tag   [NSRC];

  logic             retry_any, free_any;
  logic [SRC_W-1:0] retry_idx, free_idx;

  always_comb begin
    retry_any = 1'b0;
    retry_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (rpend[i]) begin retry_any = 1'b1; retry_idx = SRC_W'(i); end
      if (!busy[i]) begin free_any  = 1'b1; free_idx  = SRC_W'(i); end
    end
  end

  // D channel decode
  logic [SRC_W-1:0]  d_src;
  logic              d_err, d_fire, d_retry, d_done;
  logic [DATA_W-1:0] d_data;
  logic              unused_d;

  assign d_src    = d_channel[d_src_lsb(DATA_W) +: SRC_W];
  assign d_err    = d_channel[d_err_lsb(DATA_W)];
  assign d_data   = d_channel[DATA_W-1:0];
  assign unused_d = ^d_channel[D_W-1 -: 9];

  assign d_ready = reset && (!rsp_valid || rsp_ready);
  assign d_fire  = d_valid && d_ready;
  assign d_retry = d_fire && busy[d_src] && d_err && (rcnt[d_src] < RCNT_W'(MAX_RETRY));
  assign d_done  = d_fire && busy[d_src] && !d_retry;

  logic a_load, pop_good, pop_bad;

  assign a_load   = !a_valid || a_ready;
  assign pop_good = h_valid && !h_bad && a_load && !retry_any && free_any;
  // Local error responses only use the rsp slot when no D completion wants it.
  assign pop_bad  = h_valid && h_bad && !d_done && (!rsp_valid || rsp_ready);
  assign fifo_pop = pop_good || pop_bad;

  function automatic logic [A_W-1:0] beat(input logic ld, input logic [SRC_W-1:0] s,
                                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
    return {ld ? GET : PUT_FULL, 3'd0, 3'(SIZE_LOG2), s, a, w};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid   <= 1'b0;
      a_channel <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      proto_err <= 1'b0;
      busy      <= '0;
      rpend     <= '0;
      is_load   <= '0;
      for (int i = 0; i < NSRC; i++) begin
        rcnt[i]    <= '0;
        e_addr[i]  <= '0;
        e_wdata[i] <= '0;
        e_tag[i]   <= '0;
      end
    end else begin
      if (a_load) begin
        a_valid <= 1'b0;
        if (retry_any) begin
          a_valid          <= 1'b1;
          a_channel        <= beat(is_load[retry_idx], retry_idx, e_addr[retry_idx], e_wdata[retry_idx]);
          rpend[retry_idx] <= 1'b0;
        end else if (pop_good) begin
          a_valid           <= 1'b1;
          a_channel         <= beat(h_load, free_idx, h_addr, h_wdata);
          busy[free_idx]    <= 1'b1;
          is_load[free_idx] <= h_load;
          e_addr[free_idx]  <= h_addr;
          e_wdata[free_idx] <= h_wdata;
          e_tag[free_idx]   <= h_tag;
        end
      end
      if (d_fire && !busy[d_src]) proto_err <= 1'b1;
      if (d_retry) begin
        rcnt[d_src]  <= rcnt[d_src] + RCNT_W'(1);
        rpend[d_src] <= 1'b1;
      end
      if (d_done) begin
        busy[d_src] <= 1'b0;
        rcnt[d_src] <= '0;
        rsp_valid   <= 1'b1;
        rsp_tag     <= e_tag[d_src];
        rsp_err     <= d_err;
        rsp_data    <= is_load[d_src] ? d_data : '0;
      end else if (pop_bad) begin
        rsp_valid <= 1'b1;
        rsp_tag   <= h_tag;
        rsp_err   <= 1'b1;
        rsp_data  <= '0;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tl_ul_master_mo.sv
// Directed bench for tl_ul_master_mo: single load, outstanding limit, retry,
// backpressure, local error completion, protocol error and async reset.
module tb_tl_ul_master_mo;
  localparam int ADDR_W = 10, DATA_W = 32, SRC_W = 2, TAG_W = 4;
  localparam int A_W = 9 + SRC_W + ADDR_W + DATA_W;
  localparam int D_W = 10 + SRC_W + DATA_W;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, BAD = 7'b0110011;

  logic              clk = 1'b0, reset = 1'b0;
  logic              req_valid = 1'b0, req_ready;
  logic [6:0]        req_opcode = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [A_W-1:0]    a_channel;
  logic              a_valid, a_ready = 1'b1;
  logic [D_W-1:0]    d_channel = '0;
  logic              d_valid = 1'b0, d_ready;
  logic              rsp_valid, rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err, proto_err;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tl_ul_master_mo dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .a_channel(a_channel), .a_valid(a_valid), .a_ready(a_ready),
    .d_channel(d_channel), .d_valid(d_valid), .d_ready(d_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [A_W-1:0] exp_a(input logic [2:0] op, input logic [SRC_W-1:0] s,
                                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {op, 3'd0, 3'd2, s, a, d};
  endfunction

  function automatic logic [D_W-1:0] mk_d(input logic [SRC_W-1:0] s, input logic e,
                                          input logic [DATA_W-1:0] d, input logic ld);
    return {(ld ? 3'd1 : 3'd0), 3'd0, 3'd2, s, e, d};
  endfunction

  task automatic set_req(input logic [6:0] op, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] w, input logic [TAG_W-1:0] t);
    req_opcode = op; req_addr = a; req_wdata = w; req_tag = t; req_valid = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; d_valid = 1'b0; a_ready = 1'b1; rsp_ready = 1'b1;
    #2 reset = 1'b0;
    #4 reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %0b exp 0", a_valid); end
    checks++; if (a_channel !== '0) begin errors++; $display("FAIL rst_a_channel: got %0h exp 0", a_channel); end
    checks++; if ({rsp_valid, rsp_err, rsp_tag, rsp_data} !== '0) begin errors++; $display("FAIL rst_rsp: got v%0b e%0b t%0h d%0h exp all 0", rsp_valid, rsp_err, rsp_tag, rsp_data); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %0b exp 0", proto_err); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready: got %0b exp 0", d_ready); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b exp 1", req_ready); end
    @(negedge clk) reset = 1'b1;
    tick();
  endtask

  task automatic test_single_lw();
    set_req(LW, 10'h10, 32'h0, 4'd3);
    tick();
    req_valid = 1'b0;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL lw_a_early: got %0b exp 0", a_valid); end
    tick();
    checks++; if (a_valid !== 1'b1 || a_channel !== exp_a(3'd4, 2'd0, 10'h10, 32'h0)) begin errors++; $display("FAIL lw_a_beat: got v%0b %0h exp v1 %0h", a_valid, a_channel, exp_a(3'd4, 2'd0, 10'h10, 32'h0)); end
    tick();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL lw_a_done: got %0b exp 0", a_valid); end
    d_channel = mk_d(2'd0, 1'b0, 32'hDEADBEEF, 1'b1); d_valid = 1'b1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL lw_d_ready: got %0b exp 1", d_ready); end
    tick();
    d_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_tag !== 4'd3 || rsp_err !== 1'b0) begin errors++; $display("FAIL lw_rsp: got v%0b d%0h t%0h e%0b exp v1 dDEADBEEF t3 e0", rsp_valid, rsp_data, rsp_tag, rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_rsp_clear: got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_outstanding();
    logic [SRC_W-1:0]  srcs  [8];
    logic [ADDR_W-1:0] addrs [8];
    int nbeats = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 6) set_req(SW, ADDR_W'(10'h20 + 4 * c), DATA_W'(32'h100 + c), TAG_W'(c));
      else req_valid = 1'b0;
      tick();
      if (a_valid === 1'b1 && nbeats < 8) begin
        srcs[nbeats] = a_channel[ADDR_W+DATA_W +: SRC_W];
        addrs[nbeats] = a_channel[DATA_W +: ADDR_W];
        nbeats++;
      end
    end
    req_valid = 1'b0;
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL out_beats: got %0d exp 4", nbeats); end
    for (int i = 0; i < 4 && i < nbeats; i++) begin
      checks++; if (srcs[i] !== SRC_W'(i) || addrs[i] !== ADDR_W'(10'h20 + 4 * i)) begin errors++; $display("FAIL out_src%0d: got s%0d a%0h exp s%0d a%0h", i, srcs[i], addrs[i], i, 10'h20 + 4 * i); end
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL out_ready_2: got %0b exp 1", req_ready); end
    set_req(SW, 10'h38, 32'h106, 4'd6);
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL out_ready_3: got %0b exp 1", req_ready); end
    set_req(SW, 10'h3C, 32'h107, 4'd7);
    tick();
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL out_ready_full: got %0b exp 0", req_ready); end
    d_channel = mk_d(2'd2, 1'b0, 32'h0, 1'b0); d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd2 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL out_rsp2: got v%0b t%0h d%0h e%0b exp v1 t2 d0 e0", rsp_valid, rsp_tag, rsp_data, rsp_err); end
    tick();
    checks++; if (a_valid !== 1'b1 || a_channel !== exp_a(3'd0, 2'd2, 10'h30, 32'h104)) begin errors++; $display("FAIL out_reissue: got v%0b %0h exp v1 %0h", a_valid, a_channel, exp_a(3'd0, 2'd2, 10'h30, 32'h104)); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL out_ready_pop: got %0b exp 1", req_ready); end
  endtask

  task automatic test_retry();
    logic [2:0] pat [2];
    pat[0] = 3'b111;
    pat[1] = 3'b011;
    do_reset();
    for (int sc = 0; sc < 2; sc++) begin
      set_req(LW, 10'h44, 32'h55, TAG_W'(9 + sc));
      tick();
      req_valid = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++; if (a_valid !== 1'b1 || a_channel !== exp_a(3'd4, 2'd0, 10'h44, 32'h55)) begin errors++; $display("FAIL retry%0d_beat%0d: got v%0b %0h exp v1 %0h", sc, k, a_valid, a_channel, exp_a(3'd4, 2'd0, 10'h44, 32'h55)); end
        tick();
        d_channel = mk_d(2'd0, pat[sc][k], DATA_W'(32'hBAD00000 + k), 1'b1); d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        if (k < 2) begin
          checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL retry%0d_norsp%0d: got %0b exp 0", sc, k, rsp_valid); end
          tick();
        end
      end
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== pat[sc][2] || rsp_tag !== TAG_W'(9 + sc) || rsp_data !== 32'hBAD00002) begin errors++; $display("FAIL retry%0d_rsp: got v%0b e%0b t%0h d%0h exp v1 e%0b t%0h dBAD00002", sc, rsp_valid, rsp_err, rsp_tag, rsp_data, pat[sc][2], 9 + sc); end
      tick();
      checks++; if (rsp_valid !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL retry%0d_idle: got rsp%0b a%0b exp 0 0", sc, rsp_valid, a_valid); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_ready = 1'b0;
    set_req(SW, 10'h80, 32'hCAFE, 4'd1);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_valid !== 1'b1 || a_channel !== exp_a(3'd0, 2'd0, 10'h80, 32'hCAFE)) begin errors++; $display("FAIL bp_hold%0d: got v%0b %0h exp v1 %0h", i, a_valid, a_channel, exp_a(3'd0, 2'd0, 10'h80, 32'hCAFE)); end
      tick();
    end
    a_ready = 1'b1;
    tick();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL bp_xfer: got %0b exp 0", a_valid); end
    rsp_ready = 1'b0;
    d_channel = mk_d(2'd0, 1'b0, 32'h0, 1'b0); d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (rsp_valid !== 1'b1 || d_ready !== 1'b0 || rsp_tag !== 4'd1) begin errors++; $display("FAIL bp_rsp_hold%0d: got v%0b dr%0b t%0h exp v1 dr0 t1", i, rsp_valid, d_ready, rsp_tag); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL bp_d_ready: got %0b exp 1", d_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_clear: got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_bad_opcode();
    do_reset();
    set_req(BAD, 10'h12, 32'h77, 4'd6);
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tag !== 4'd6 || rsp_data !== 32'h0 || a_valid !== 1'b0) begin errors++; $display("FAIL bad_rsp: got v%0b e%0b t%0h d%0h a%0b exp v1 e1 t6 d0 a0", rsp_valid, rsp_err, rsp_tag, rsp_data, a_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL bad_idle: got v%0b a%0b exp 0 0", rsp_valid, a_valid); end
  endtask

  task automatic test_proto_reset();
    do_reset();
    d_channel = mk_d(2'd1, 1'b0, 32'h0, 1'b0); d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    tick(); tick();
    checks++; if (proto_err !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL pe_sticky: got pe%0b v%0b exp pe1 v0", proto_err, rsp_valid); end
    for (int i = 0; i < 3; i++) begin
      set_req(LW, ADDR_W'(4 * i), 32'h0, TAG_W'(i));
      tick();
    end
    req_valid = 1'b0;
    tick(); tick();
    a_ready = 1'b0;
    set_req(LW, 10'h0C, 32'h0, 4'd3);
    tick();
    req_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    d_channel = mk_d(2'd0, 1'b0, 32'h1234, 1'b1); d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    checks++; if (a_valid !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 32'h1234) begin errors++; $display("FAIL pe_pre: got a%0b v%0b d%0h exp a1 v1 d1234", a_valid, rsp_valid, rsp_data); end
    #2 reset = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0 || rsp_valid !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL pe_async_rst: got a%0b v%0b pe%0b exp 0 0 0", a_valid, rsp_valid, proto_err); end
    #1 reset = 1'b1;
    rsp_ready = 1'b1; a_ready = 1'b1;
    tick(); tick();
    checks++; if (proto_err !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL pe_after_rst: got pe%0b a%0b exp 0 0", proto_err, a_valid); end
    d_channel = mk_d(2'd2, 1'b0, 32'h0, 1'b1); d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    checks++; if (proto_err !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL pe_late_d: got pe%0b v%0b exp pe1 v0", proto_err, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_lw();
    test_outstanding();
    test_retry();
    test_backpressure();
    test_bad_opcode();
    test_proto_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
